// File: rtl/flag_gen_if.sv
// flag_gen bus: ALU result, flag update controls and flag/stack status.
// master drives requests, slave (flag_gen) drives the flag outputs.
interface flag_gen_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             shift_c;
  logic [3:0]       we;
  logic             ld;
  logic [3:0]       ld_data;
  logic             push;
  logic             pop;
  logic             n;
  logic             z;
  logic             v;
  logic             c;
  logic [3:0]       flags;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output valid, op, a, b, result,
    output cout, shift_c, we, ld, ld_data,
    output push, pop,
    input  n, z, v, c, flags,
    input  full, empty, err
  );

  modport slave (
    input  valid, op, a, b, result,
    input  cout, shift_c, we, ld, ld_data,
    input  push, pop,
    output n, z, v, c, flags,
    output full, empty, err
  );
endinterface

// File: rtl/flag_gen.sv
// N/Z/V/C flag register with write mask, load and optional LIFO save.
// Define FLAG_STACK_EN to build the push/pop flag stack.
module flag_gen #(
  parameter int WIDTH       = 8,
  parameter int STACK_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  flag_gen_if.slave bus
);
  localparam int M = WIDTH - 1;

  logic [3:0] flags_q;
  logic [3:0] alu_f;
  logic [3:0] upd_f;
  logic [3:0] next_f;
  logic       alu_v;
  logic       alu_c;

  always_comb begin
    alu_v = 1'b0;
    alu_c = 1'b0;
    unique case (1'b1)
      (bus.op == 2'b01): begin
        alu_v = (bus.a[M] == bus.b[M]) &&
                (bus.result[M] != bus.a[M]);
        alu_c = bus.cout;
      end
      (bus.op == 2'b10): begin
        alu_v = (bus.a[M] != bus.b[M]) &&
                (bus.result[M] != bus.a[M]);
        alu_c = bus.cout;
      end
      (bus.op == 2'b11): alu_c = bus.shift_c;
      default: ;
    endcase
  end

  assign alu_f = {bus.result[M], ~|bus.result,
                  alu_v, alu_c};
  assign upd_f = (alu_f & bus.we) |
                 (flags_q & ~bus.we);

  // load beats the ALU update
  always_comb begin
    next_f = flags_q;
    if (bus.ld)
      next_f = bus.ld_data;
    else if (bus.valid)
      next_f = upd_f;
  end

  assign bus.flags = flags_q;
  assign bus.n     = flags_q[3];
  assign bus.z     = flags_q[2];
  assign bus.v     = flags_q[1];
  assign bus.c     = flags_q[0];

`ifdef FLAG_STACK_EN
  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int IW = (STACK_DEPTH > 1) ?
                      $clog2(STACK_DEPTH) : 1;

  logic [3:0]    stack [STACK_DEPTH];
  logic [CW-1:0] count;
  logic          err_q;
  logic          full;
  logic          empty;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;

  assign full    = (count == CW'(STACK_DEPTH));
  assign empty   = (count == '0);
  assign top_idx = IW'(count - CW'(1));
  assign wr_idx  = IW'(count);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      count   <= '0;
      err_q   <= 1'b0;
    end else if (bus.pop && !empty) begin
      // pop wins; with push it becomes a top swap
      flags_q <= stack[top_idx];
      if (bus.push)
        stack[top_idx] <= flags_q;
      else
        count <= count - CW'(1);
    end else begin
      flags_q <= next_f;
      if (bus.push) begin
        if (full) begin
          err_q <= 1'b1;
        end else begin
          stack[wr_idx] <= flags_q;
          count         <= count + CW'(1);
        end
      end
      if (bus.pop)
        err_q <= 1'b1;
    end
  end

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.err   = err_q;
`else
  always_ff @(posedge clk) begin
    if (rst)
      flags_q <= '0;
    else
      flags_q <= next_f;
  end

  assign bus.full  = 1'b0;
  assign bus.empty = 1'b1;
  assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_flag_gen.sv
// Self-checking bench for flag_gen with an expected-flags queue.
// Stack scenarios run when FLAG_STACK_EN is defined.
module tb_flag_gen;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_gen_if #(.WIDTH(WIDTH)) bus ();

  flag_gen #(
    .WIDTH(WIDTH),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q [$];
  logic [3:0] exp;

  task automatic idle();
    bus.valid   = 1'b0;
    bus.op      = 2'b00;
    bus.a       = '0;
    bus.b       = '0;
    bus.result  = '0;
    bus.cout    = 1'b0;
    bus.shift_c = 1'b0;
    bus.we      = 4'b0000;
    bus.ld      = 1'b0;
    bus.ld_data = 4'b0000;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(
    input logic [1:0] op,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] r,
    input logic       co,
    input logic       sc,
    input logic [3:0] we
  );
    bus.valid   = 1'b1;
    bus.op      = op;
    bus.a       = a;
    bus.b       = b;
    bus.result  = r;
    bus.cout    = co;
    bus.shift_c = sc;
    bus.we      = we;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    bus.valid   = 1'b1;
    bus.we      = 4'b1111;
    bus.ld      = 1'b1;
    bus.ld_data = 4'b1111;
    bus.push    = 1'b1;
    exp_q.push_back(4'b0000);
    tick();
    rst = 1'b0;
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b",
               bus.flags, exp);
    end
    checks++;
    if ({bus.n, bus.z, bus.v, bus.c} !== exp) begin
      failures++;
      $display("FAIL reset_nzvc got=%b exp=%b",
               {bus.n, bus.z, bus.v, bus.c}, exp);
    end
    checks++;
    if (bus.empty !== 1'b1) begin
      failures++;
      $display("FAIL reset_empty got=%b exp=1",
               bus.empty);
    end
    checks++;
    if (bus.full !== 1'b0) begin
      failures++;
      $display("FAIL reset_full got=%b exp=0",
               bus.full);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("FAIL reset_err got=%b exp=0",
               bus.err);
    end
  endtask

  task automatic test_add();
    idle();
    drive_alu(2'b01, 8'h7F, 8'h01, 8'h80,
              1'b0, 1'b0, 4'b1111);
    exp_q.push_back(4'b1010);
    tick();
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL add_flags got=%b exp=%b",
               bus.flags, exp);
    end
    checks++;
    if ({bus.n, bus.z, bus.v, bus.c} !== exp) begin
      failures++;
      $display("FAIL add_nzvc got=%b exp=%b",
               {bus.n, bus.z, bus.v, bus.c}, exp);
    end
  endtask

  task automatic test_sub();
    logic [7:0] ta [2] = '{8'h05, 8'h80};
    logic [7:0] tb [2] = '{8'h05, 8'h01};
    logic [7:0] tr [2] = '{8'h00, 8'h7F};
    logic [3:0] te [2] = '{4'b0101, 4'b0011};
    for (int i = 0; i < 2; i++) begin
      idle();
      drive_alu(2'b10, ta[i], tb[i], tr[i],
                1'b1, 1'b0, 4'b1111);
      exp_q.push_back(te[i]);
      tick();
      idle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.flags !== exp) begin
        failures++;
        $display("FAIL sub_%0d got=%b exp=%b",
                 i, bus.flags, exp);
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] got;
    for (int i = 0; i < 5; i++) begin
      idle();
      unique case (i)
        0: begin
          bus.ld      = 1'b1;
          bus.ld_data = 4'b1011;
          exp_q.push_back(4'b1011);
        end
        1: begin
          drive_alu(2'b00, 8'h3C, 8'h00, 8'h00,
                    1'b1, 1'b1, 4'b0100);
          exp_q.push_back(4'b1111);
        end
        2: begin
          drive_alu(2'b01, 8'h00, 8'h00, 8'h00,
                    1'b1, 1'b0, 4'b1111);
          bus.ld      = 1'b1;
          bus.ld_data = 4'b0110;
          exp_q.push_back(4'b0110);
        end
        3: begin
          drive_alu(2'b11, 8'h81, 8'h00, 8'h02,
                    1'b0, 1'b1, 4'b1111);
          exp_q.push_back(4'b0001);
        end
        default: begin
          drive_alu(2'b00, 8'hF0, 8'hFF, 8'hF0,
                    1'b1, 1'b1, 4'b1111);
          exp_q.push_back(4'b1000);
        end
      endcase
      tick();
      got = bus.flags;
      idle();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL mask_%0d got=%b exp=%b",
                 i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] mf;
    logic [3:0] ef;
    logic [1:0] op;
    logic [7:0] a, b, r;
    logic [8:0] s9;
    logic [3:0] we;
    logic       co, sc, ev, ec;
    int         sv;
    idle();
    bus.ld      = 1'b1;
    bus.ld_data = 4'b0000;
    exp_q.push_back(4'b0000);
    tick();
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL b2b_init got=%b exp=%b",
               bus.flags, exp);
    end
    mf = 4'b0000;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      b  = 8'($urandom);
      we = 4'($urandom);
      co = 1'($urandom);
      sc = 1'($urandom);
      ev = 1'b0;
      ec = 1'b0;
      case (op)
        2'b01: begin
          s9 = {1'b0, a} + {1'b0, b};
          r  = s9[7:0];
          co = s9[8];
          sv = int'($signed(a)) + int'($signed(b));
          ev = (sv > 127) || (sv < -128);
          ec = co;
        end
        2'b10: begin
          s9 = {1'b0, a} + {1'b0, ~b} + 9'd1;
          r  = s9[7:0];
          co = s9[8];
          sv = int'($signed(a)) - int'($signed(b));
          ev = (sv > 127) || (sv < -128);
          ec = co;
        end
        2'b11: begin
          r  = {a[6:0], 1'b0};
          sc = a[7];
          ec = sc;
        end
        default: r = a ^ b;
      endcase
      ef = {r[7], (r == 8'h00), ev, ec};
      mf = (ef & we) | (mf & ~we);
      drive_alu(op, a, b, r, co, sc, we);
      exp_q.push_back(mf);
      tick();
      exp = exp_q.pop_front();
      checks++;
      if (bus.flags !== exp) begin
        failures++;
        $display("FAIL b2b_%0d op=%b got=%b exp=%b",
                 i, op, bus.flags, exp);
      end
    end
    idle();
  endtask

`ifdef FLAG_STACK_EN
  task automatic test_stack();
    logic [3:0] ld_v [4] = '{4'b0001, 4'b0010,
                             4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.push = (i > 0);
      if (i < 4) begin
        bus.ld      = 1'b1;
        bus.ld_data = ld_v[i];
        exp_q.push_back(ld_v[i]);
      end else begin
        exp_q.push_back(4'b1000);
      end
      tick();
      idle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.flags !== exp) begin
        failures++;
        $display("FAIL fill_%0d got=%b exp=%b",
                 i, bus.flags, exp);
      end
    end
    checks++;
    if (bus.full !== 1'b1 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL full got=%b%b exp=10",
               bus.full, bus.err);
    end
    bus.push = 1'b1;
    tick();
    idle();
    checks++;
    if (bus.err !== 1'b1 || bus.full !== 1'b1) begin
      failures++;
      $display("FAIL overflow got=%b%b exp=11",
               bus.err, bus.full);
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.pop = 1'b1;
      exp_q.push_back(ld_v[(i < 4) ? 3 - i : 0]);
      tick();
      idle();
      exp = exp_q.pop_front();
      checks++;
      if (bus.flags !== exp) begin
        failures++;
        $display("FAIL pop_%0d got=%b exp=%b",
                 i, bus.flags, exp);
      end
      checks++;
      if (bus.empty !== (i >= 3)) begin
        failures++;
        $display("FAIL pop_empty_%0d got=%b exp=%b",
                 i, bus.empty, (i >= 3));
      end
    end
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL underflow got=%b exp=1", bus.err);
    end
  endtask

  task automatic test_swap();
    logic [3:0] got;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      unique case (i)
        0: begin
          bus.ld = 1'b1; bus.ld_data = 4'b0101;
          exp_q.push_back(4'b0101);
        end
        1: begin
          bus.push = 1'b1;
          bus.ld = 1'b1; bus.ld_data = 4'b1010;
          exp_q.push_back(4'b1010);
        end
        2: begin
          bus.push = 1'b1; bus.pop = 1'b1;
          exp_q.push_back(4'b0101);
        end
        3: begin
          bus.pop = 1'b1;
          exp_q.push_back(4'b1010);
        end
        4: begin
          bus.push = 1'b1; bus.pop = 1'b1;
          bus.ld = 1'b1; bus.ld_data = 4'b0110;
          exp_q.push_back(4'b0110);
        end
        default: begin
          bus.pop = 1'b1;
          exp_q.push_back(4'b1010);
        end
      endcase
      tick();
      got = bus.flags;
      idle();
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL swap_%0d got=%b exp=%b",
                 i, got, exp);
      end
      checks++;
      if (bus.empty !== (i == 3 || i == 5) ||
          bus.err !== (i >= 4)) begin
        failures++;
        $display("FAIL swap_st_%0d got=%b%b",
                 i, bus.empty, bus.err);
      end
    end
  endtask
`else
  task automatic test_stack_disabled();
    idle();
    bus.ld      = 1'b1;
    bus.ld_data = 4'b1001;
    exp_q.push_back(4'b1001);
    tick();
    idle();
    bus.push = 1'b1;
    bus.pop  = 1'b1;
    exp_q.push_back(4'b1001);
    tick();
    exp = exp_q.pop_front();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL nostack_hold got=%b exp=%b",
               bus.flags, exp);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.err !== 1'b0) begin
      failures++;
      $display("FAIL nostack_st got=%b%b%b exp=100",
               bus.empty, bus.full, bus.err);
    end
    bus.ld      = 1'b1;
    bus.ld_data = 4'b0110;
    exp_q.push_back(4'b0110);
    tick();
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL nostack_ld got=%b exp=%b",
               bus.flags, exp);
    end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    idle();
    bus.pop     = 1'b1;
    bus.ld      = 1'b1;
    bus.ld_data = 4'b0011;
    exp_q.push_back(4'b0011);
    tick();
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL rmid_pop_empty got=%b exp=%b",
               bus.flags, exp);
    end
`ifdef FLAG_STACK_EN
    checks++;
    if (bus.err !== 1'b1) begin
      failures++;
      $display("FAIL rmid_err got=%b exp=1", bus.err);
    end
`endif
    bus.push = 1'b1;
    tick();
    bus.ld      = 1'b1;
    bus.ld_data = 4'b1111;
    tick();
    idle();
    rst = 1'b1;
    bus.pop   = 1'b1;
    bus.push  = 1'b1;
    drive_alu(2'b01, 8'h7F, 8'h01, 8'h80,
              1'b0, 1'b0, 4'b1111);
    exp_q.push_back(4'b0000);
    tick();
    rst = 1'b0;
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (bus.flags !== exp) begin
      failures++;
      $display("FAIL rmid_flags got=%b exp=%b",
               bus.flags, exp);
    end
    checks++;
    if (bus.empty !== 1'b1 || bus.err !== 1'b0 ||
        bus.full !== 1'b0) begin
      failures++;
      $display("FAIL rmid_st got=%b%b%b exp=100",
               bus.empty, bus.err, bus.full);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_add();
    test_sub();
    test_mask();
    test_back_to_back();
`ifdef FLAG_STACK_EN
    test_stack();
    test_swap();
`else
    test_stack_disabled();
`endif
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL queue_left got=%0d exp=0",
               exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/flag_gen.md
# flag_gen

Condition-flag producer for the RISC CPU control path. It derives N, Z, V and C from each ALU result, holds them in a registered status word with per-flag write masking and a direct-load path, and optionally saves and restores them on a small LIFO for interrupt entry and return. Its registered outputs drive the flag inputs of the branch-condition selector.

## Interface

Parameters:
- WIDTH, 8, datapath width of operands and result.
- STACK_DEPTH, 4, number of flag-stack entries; must be at least 2. Used only with FLAG_STACK_EN.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_valid  input  1  ALU result valid this cycle; flag update requested.
- i_op  input  2  flag rule: 00 logic, 01 add, 10 sub, 11 shift.
- i_a  input  WIDTH  ALU operand A.
- i_b  input  WIDTH  ALU operand B.
- i_result  input  WIDTH  ALU result.
- i_cout  input  1  adder carry-out; for sub, carry of a + ~b + 1.
- i_shift_c  input  1  bit shifted out, used for shift ops.
- i_we  input  4  per-flag update mask {N,Z,V,C}; bit 3 is N, bit 0 is C.
- i_ld  input  1  direct load of the flags.
- i_ld_data  input  4  load value {N,Z,V,C}.
- i_push  input  1  push the current flags onto the stack.
- i_pop  input  1  restore the flags from the stack top.
- o_n, o_z, o_v, o_c  output  1 each  registered flags.
- o_flags  output  4  {o_n,o_z,o_v,o_c}.
- o_full  output  1  stack holds STACK_DEPTH entries.
- o_empty  output  1  stack holds no entries.
- o_err  output  1  sticky stack overflow or underflow.

## Operation

Flag computation, with m = WIDTH-1:
- N = i_result[m].
- Z = (i_result == 0).
- Add: V = (a[m] == b[m]) & (r[m] != a[m]); C = i_cout.
- Sub: V = (a[m] != b[m]) & (r[m] != a[m]); C = i_cout, so 1 means no borrow.
- Logic: V = 0, C = 0.
- Shift: V = 0, C = i_shift_c.

Update priority per cycle, highest first:
1. i_rst
2. i_pop
3. i_ld
4. i_valid

Rules:
- Under i_valid, only flags whose i_we bit is 1 change. The others hold.
- i_ld writes all four flags and ignores i_we.
- If both i_ld and i_valid are asserted, the i_ld value is taken and the ALU update is discarded.

Flag stack (FLAG_STACK_EN):
- Push writes o_flags as they stand before this edge into entry[count], then increments count. A same-cycle i_valid or i_ld still updates the flags.
- Pop loads the flags from entry[count-1] and decrements count. Pop overrides i_ld and i_valid.
- Push with pop while not empty is a swap. The top entry takes the current flags, the flags take the old top, and count is unchanged.
- Push when full: no write, count unchanged, o_err goes to 1.
- Pop when empty: flags follow the normal i_ld/i_valid rules, o_err goes to 1.
- Push with pop when empty: the push proceeds, the pop is ignored, o_err goes to 1.
- o_err stays set until i_rst.
- o_full = (count == STACK_DEPTH); o_empty = (count == 0). Both are derived from the count register.

## Timing

- Reset values:
  - o_n, o_z, o_v, o_c = 0; o_flags = 4'b0000.
  - count = 0, so o_empty = 1 and o_full = 0.
  - o_err = 0.
  - Stack contents are don't-care.
- Latency:
  - Inputs sampled at edge k appear on the flags after edge k; the branch selector sees them in cycle k+1.
  - There is no combinational path from any input to any output.
- Back-to-back i_valid every cycle is supported, and each result is reflected exactly one cycle later.
- Asserting i_rst during any stack or update activity clears all state at that edge. Same-cycle push, pop, ld and valid are ignored.

## Configuration

FLAG_STACK_EN:
- Defined: stack storage, count, o_full/o_empty/o_err logic and push/pop behaviour as specified above are compiled in.
- Undefined:
  - No stack storage is synthesised.
  - i_push and i_pop remain as ports but are ignored.
  - o_full = 0, o_empty = 1, o_err = 0 constantly.
  - Flag computation, masking and load are unchanged.

## Test plan

WIDTH=8, STACK_DEPTH=4.
- Add: a=0x7F, b=0x01, r=0x80, cout=0, we=1111 → next cycle flags=1010 (N=1, Z=0, V=1, C=0).
- Sub: a=0x05, b=0x05, r=0x00, cout=1, we=1111 → flags=0101. Then sub a=0x80, b=0x01, r=0x7F, cout=1 → flags=0011.
- Masking: from flags=1011, logic r=0x00 with we=0100 → flags=1111 (only Z changed). Then i_ld=1, i_ld_data=0110 together with valid add r=0x00 → flags=0110.
- Stack (FLAG_STACK_EN):
  - Load 0001, 0010, 0100, 1000, pushing after each → o_full=1.
  - Fifth push → o_err=1, count stays 4.
  - Four pops → flags 1000, 0100, 0010, 0001 in that order, then o_empty=1.
  - One more pop → flags unchanged, o_err stays 1.
- Swap: with one entry 0101 and flags 1010, push+pop → flags=0101, top entry=1010, count=1.
- Reset mid-operation: after two pushes and flags=1111, i_rst one cycle alongside i_pop → next cycle flags=0000, o_empty=1, o_err=0.
